// File: rtl/instr_encoder.sv
// Encodes ALU operation requests into MIPS R/I-type words and streams them,
// through a small FIFO, into sequential instruction memory addresses.
module instr_encoder #(
    parameter int          ADDR_W     = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_alu,
    input  logic              req_imm,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [15:0]       req_imm16,

    input  logic              im_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,

    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              mem_full
);

    // alu_* operation codes shared with the decoder (mips_para.v)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST    = {ADDR_W{1'b1}};

    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic        r_ok;
    logic        i_ok;
    logic        enc_legal;
    logic [31:0] enc_word;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              mem_full_reg;
    logic              err_reg;
    logic [7:0]        err_cnt_reg;

    logic accept;
    logic push;
    logic pop;
    logic reject;
    logic empty;

    // Instruction encoding: r_ok/i_ok mark which forms exist for the operation
    always_comb begin
        funct  = 6'h00;
        opcode = 6'h00;
        r_ok   = 1'b0;
        i_ok   = 1'b0;
        case (req_alu)
            ALU_ADD:  begin funct = 6'h20; opcode = 6'h08; r_ok = 1'b1; i_ok = 1'b1; end
            ALU_SUB:  begin funct = 6'h22;                 r_ok = 1'b1;             end
            ALU_AND:  begin funct = 6'h24; opcode = 6'h0C; r_ok = 1'b1; i_ok = 1'b1; end
            ALU_OR:   begin funct = 6'h25; opcode = 6'h0D; r_ok = 1'b1; i_ok = 1'b1; end
            ALU_XOR:  begin funct = 6'h26; opcode = 6'h0E; r_ok = 1'b1; i_ok = 1'b1; end
            ALU_SLT:  begin funct = 6'h2A; opcode = 6'h0A; r_ok = 1'b1; i_ok = 1'b1; end
            ALU_SLTU: begin funct = 6'h2B;                 r_ok = 1'b1;             end
            default:  ;
        endcase
        enc_legal = req_imm ? i_ok : r_ok;
        // I-type places the destination in the rt field
        enc_word  = req_imm ? {opcode, req_rs, req_rd, req_imm16}
                            : {6'h00, req_rs, req_rt, req_rd, 5'h00, funct};
    end

    assign empty     = (count_reg == '0);
    assign req_ready = (count_reg != DEPTH_CNT);
    assign accept    = req_valid && req_ready;
    assign push      = accept && enc_legal && !clr;
    assign reject    = accept && !enc_legal;
    assign im_we     = !empty && im_ready && !mem_full_reg;
    assign pop       = im_we && !clr;

    assign im_addr   = addr_reg;
    assign im_wdata  = empty ? 32'h0 : fifo_mem[rd_ptr_reg];
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;
    assign mem_full  = mem_full_reg;

    // Storage carries no reset; stale entries are never visible past count_reg
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= enc_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            addr_reg     <= BASE;
            mem_full_reg <= 1'b0;
            err_reg      <= 1'b0;
            err_cnt_reg  <= 8'h00;
        end else if (clr) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            addr_reg     <= BASE;
            mem_full_reg <= 1'b0;
            err_reg      <= 1'b0;
            err_cnt_reg  <= 8'h00;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: ;
            endcase
            // The last address is written once; the counter then parks there
            if (pop) begin
                if (addr_reg == LAST) begin
                    mem_full_reg <= 1'b1;
                end else begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                end
            end
            err_reg <= reject;
            if (reject && err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed check of instr_encoder against a queue-based model.
module tb_instr_encoder;

    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_alu;
    logic              req_imm;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [15:0]       req_imm16;
    logic              im_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              err;
    logic [7:0]        err_cnt;
    logic              mem_full;

    instr_encoder #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (0),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_alu   (req_alu),
        .req_imm   (req_imm),
        .req_rd    (req_rd),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .req_imm16 (req_imm16),
        .im_ready  (im_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .err       (err),
        .err_cnt   (err_cnt),
        .mem_full  (mem_full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state
    logic [31:0] m_q[$];
    int          m_addr;
    bit          m_full;
    bit          m_err;
    int          m_err_cnt;

    // Codes 0..6 = add, sub, and, or, xor, slt, sltu; -1 = no such form
    int funct_t[7] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h2A, 32'h2B};
    int op_t[7]    = '{32'h08, -1, 32'h0C, 32'h0D, 32'h0E, 32'h0A, -1};

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_encode(input int alu, input bit imm, input int rd,
                                               input int rs, input int rt, input int imm16);
        logic [31:0] w;
        if (alu > 6) return 33'h0;
        if (imm) begin
            if (op_t[alu] < 0) return 33'h0;
            w = 32'(op_t[alu] * (1 << 26) + rs * (1 << 21) + rd * (1 << 16) + imm16);
        end else begin
            w = 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + funct_t[alu]);
        end
        return {1'b1, w};
    endfunction

    task automatic reset_model();
        m_q.delete();
        m_addr    = 0;
        m_full    = 0;
        m_err     = 0;
        m_err_cnt = 0;
    endtask

    task automatic model_step();
        bit          rdy;
        bit          we;
        logic [32:0] enc;
        logic [31:0] dropped;
        if (!rst_n || clr) begin
            reset_model();
            return;
        end
        rdy   = m_q.size() < FIFO_DEPTH;
        we    = m_q.size() != 0 && im_ready && !m_full;
        m_err = 0;
        if (we) begin
            dropped = m_q.pop_front();
            if (m_addr == (1 << ADDR_W) - 1) m_full = 1;
            else m_addr++;
        end
        if (req_valid && rdy) begin
            enc = ref_encode(int'(req_alu), req_imm, int'(req_rd), int'(req_rs),
                             int'(req_rt), int'(req_imm16));
            if (enc[32]) begin
                m_q.push_back(enc[31:0]);
            end else begin
                m_err = 1;
                if (m_err_cnt < 255) m_err_cnt++;
            end
        end
    endtask

    task automatic compare_all();
        check_value("req_ready", req_ready, m_q.size() < FIFO_DEPTH);
        check_value("im_we", im_we, m_q.size() != 0 && im_ready && !m_full);
        check_value("im_addr", im_addr, m_addr);
        check_value("im_wdata", im_wdata, m_q.size() != 0 ? m_q[0] : 32'h0);
        check_value("err", err, m_err);
        check_value("err_cnt", err_cnt, m_err_cnt);
        check_value("mem_full", mem_full, m_full);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input int alu, input bit imm, input int rd, input int rs,
                           input int rt, input int imm16);
        req_valid = 1'b1;
        req_alu   = 4'(alu);
        req_imm   = imm;
        req_rd    = 5'(rd);
        req_rs    = 5'(rs);
        req_rt    = 5'(rt);
        req_imm16 = 16'(imm16);
    endtask

    task automatic rand_req();
        set_req($urandom_range(0, 9), 1'($urandom), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
    endtask

    task automatic do_clr();
        req_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; im_ready = 1'b1;
        req_valid = 1'b0; req_alu = '0; req_imm = 1'b0;
        req_rd = '0; req_rs = '0; req_rt = '0; req_imm16 = '0;
        reset_model();
        #3;
        compare_all();
        tick();
        rst_n = 1'b1;
        tick();

        // ADD rd=3 rs=1 rt=2
        set_req(0, 0, 3, 1, 2, 0);
        tick();
        req_valid = 1'b0;
        check_value("add_we", im_we, 1'b1);
        check_value("add_addr", im_addr, 32'h0);
        check_value("add_word", im_wdata, 32'h00221820);
        tick();

        // ADDI, ORI, SLTU back to back
        do_clr();
        set_req(0, 1, 5, 0, 0, 16'h0010);
        tick();
        check_value("addi_word", im_wdata, 32'h20050010);
        check_value("addi_addr", im_addr, 32'h0);
        set_req(3, 1, 4, 4, 0, 16'hFFFF);
        tick();
        check_value("ori_word", im_wdata, 32'h3484FFFF);
        check_value("ori_addr", im_addr, 32'h1);
        set_req(6, 0, 8, 9, 10, 0);
        tick();
        check_value("sltu_word", im_wdata, 32'h012A402B);
        check_value("sltu_addr", im_addr, 32'h2);
        req_valid = 1'b0;
        tick();

        // Back-pressure: 5 requests with memory stalled
        do_clr();
        im_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(i % 6, 0, i + 1, i + 2, i + 3, 0);
            tick();
        end
        req_valid = 1'b0;
        check_value("bp_ready_low", req_ready, 1'b0);
        check_value("bp_addr_held", im_addr, 32'h0);
        im_ready = 1'b1;
        tick();
        check_value("bp_ready_back", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) tick();

        // Illegal SUBI then ADD
        do_clr();
        set_req(1, 1, 2, 3, 4, 16'h1234);
        tick();
        check_value("subi_err", err, 1'b1);
        check_value("subi_we", im_we, 1'b0);
        set_req(0, 0, 7, 6, 5, 0);
        tick();
        req_valid = 1'b0;
        check_value("subi_err_drop", err, 1'b0);
        check_value("subi_cnt", err_cnt, 8'd1);
        check_value("subi_add_addr", im_addr, 32'h0);
        tick();

        // Fill the whole address space
        do_clr();
        for (int i = 0; i < 262; i++) begin
            set_req($urandom_range(0, 6), 0, $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 31), 0);
            tick();
        end
        req_valid = 1'b0;
        check_value("full_flag", mem_full, 1'b1);
        check_value("full_we", im_we, 1'b0);
        check_value("full_addr", im_addr, 32'hFF);
        check_value("full_ready", req_ready, 1'b0);
        tick();
        do_clr();
        check_value("clr_addr", im_addr, 32'h0);
        check_value("clr_full", mem_full, 1'b0);
        check_value("clr_ready", req_ready, 1'b1);

        // Async reset mid-stream with 3 words buffered
        im_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(2, 1, i, i, 0, i);
            tick();
        end
        req_valid = 1'b0;
        im_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_value("arst_we", im_we, 1'b0);
        check_value("arst_wdata", im_wdata, 32'h0);
        compare_all();
        tick();
        rst_n = 1'b1;
        set_req(4, 0, 1, 1, 1, 0);
        tick();
        req_valid = 1'b0;
        check_value("arst_restart_addr", im_addr, 32'h0);
        check_value("arst_restart_we", im_we, 1'b1);
        tick();

        // Error counter saturation
        do_clr();
        for (int i = 0; i < 300; i++) begin
            set_req(6, 1, 1, 1, 1, 0);
            tick();
        end
        req_valid = 1'b0;
        tick();
        check_value("err_sat", err_cnt, 8'd255);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0) rand_req();
            else req_valid = 1'b0;
            im_ready = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 299) == 0);
            tick();
        end
        clr = 1'b0;
        req_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
